// File: rtl/aq_djpeg_idct_xpose.sv
// aq_djpeg_idct_xpose: double-buffered 8x8 transpose buffer between the row
// and column passes of the 2-D IDCT.
// Row results are descaled, rounded and stored transposed as 16-bit words.
// Columns are served in pairs to the column pass.
// Optional feature macro: AQ_DJPEG_XPOSE_SAT_EN.
// When it is defined, stored values clamp to [-32768, 32767].
// When it is undefined, stored values keep the low 16 bits and wrap.
module aq_djpeg_idct_xpose #(
  parameter int DESCALE = 12
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        RowEnable,
  input  logic [2:0]  RowPage,
  input  logic [1:0]  RowCount,
  input  logic [31:0] Row0Data,
  input  logic [31:0] Row1Data,
  output logic        RowReady,
  output logic        Overrun,
  output logic        ColEnable,
  input  logic        ColRead,
  input  logic [4:0]  ColAddress,
  output logic [15:0] ColDataA,
  output logic [15:0] ColDataB
);

  localparam logic signed [32:0] ROUND = 33'sd1 <<< (DESCALE - 1);

  // Round-half-up descale of a 32-bit row result into a 16-bit stored value.
  function automatic logic [15:0] sat(input logic [31:0] x);
    logic signed [32:0] sum;
    logic signed [32:0] shifted;
    sum     = $signed({x[31], x}) + ROUND;
    shifted = sum >>> DESCALE;
`ifdef AQ_DJPEG_XPOSE_SAT_EN
    if (shifted > 33'sd32767) begin
      return 16'h7fff;
    end
    if (shifted < -33'sd32768) begin
      return 16'h8000;
    end
    return shifted[15:0];
`else
    return shifted[15:0];
`endif
  endfunction

  // Two banks of 8 rows x 8 columns, addressed as {bank, row, col}.
  logic [15:0] mem [0:127];

  logic [1:0] full;
  logic       wp;
  logic       rp;
  logic       reading;
  logic [4:0] rc;
  logic       overrun;

  logic       row_ready;
  logic       col_enable;
  logic       wr_accept;
  logic       wr_done;
  logic       rd_accept;
  logic       rd_first;
  logic       rd_done;
  logic [1:0] full_next;

  logic [2:0] wr_col0;
  logic [2:0] wr_col1;
  logic [2:0] page;
  logic [1:0] cnt;
  logic [2:0] row_a;
  logic [2:0] row_b;

  assign page    = ColAddress[4:2];
  assign cnt     = ColAddress[1:0];
  assign wr_col0 = {1'b0, RowCount};
  assign wr_col1 = 3'd7 - {1'b0, RowCount};

  // Handshake decodes; rc counts reads already served, so rc==31 marks the last.
  always_comb begin
    row_ready  = !full[wp];
    col_enable = full[rp] & !reading;
    wr_accept  = RowEnable & row_ready;
    wr_done    = wr_accept & (RowPage == 3'd7) & (RowCount == 2'd3);
    rd_first   = ColRead & col_enable;
    rd_accept  = ColRead & (col_enable | reading);
    rd_done    = ColRead & reading & (rc == 5'd31);
    full_next  = full;
    if (wr_done) begin
      full_next[wp] = 1'b1;
    end
    if (rd_done) begin
      full_next[rp] = 1'b0;
    end
  end

  // Row-pair selection for a column read: even rows first, then the odd pairs.
  always_comb begin
    row_a = 3'd0;
    row_b = 3'd4;
    case (cnt)
      2'd0: begin row_a = 3'd0; row_b = 3'd4; end
      2'd1: begin row_a = 3'd2; row_b = 3'd6; end
      2'd2: begin row_a = 3'd1; row_b = 3'd7; end
      default: begin row_a = 3'd5; row_b = 3'd3; end
    endcase
  end

  // Transposed storage write: both beat elements land in row RowPage of bank wp.
  always_ff @(posedge clk) begin
    if (wr_accept) begin
      mem[{wp, RowPage, wr_col0}] <= sat(Row0Data);
      mem[{wp, RowPage, wr_col1}] <= sat(Row1Data);
    end
  end

  // Bank bookkeeping: fill/release flags, ping-pong pointers and read counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      full    <= 2'b00;
      wp      <= 1'b0;
      rp      <= 1'b0;
      reading <= 1'b0;
      rc      <= 5'd0;
      overrun <= 1'b0;
    end else begin
      full <= full_next;
      if (RowEnable && !row_ready) begin
        overrun <= 1'b1;
      end
      if (wr_done) begin
        wp <= ~wp;
      end
      if (rd_done) begin
        reading <= 1'b0;
        rc      <= 5'd0;
        rp      <= ~rp;
      end else if (rd_first) begin
        reading <= 1'b1;
        rc      <= 5'd1;
      end else if (rd_accept) begin
        rc <= rc + 5'd1;
      end
    end
  end

  // Column pair output register; holds its value between reads.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ColDataA <= 16'd0;
      ColDataB <= 16'd0;
    end else if (rd_accept) begin
      ColDataA <= mem[{rp, row_a, page}];
      ColDataB <= mem[{rp, row_b, page}];
    end
  end

  assign RowReady  = row_ready;
  assign ColEnable = col_enable;
  assign Overrun   = overrun;

endmodule

// File: tb/tb_aq_djpeg_idct_xpose.sv
// tb_aq_djpeg_idct_xpose: directed bench for the IDCT transpose buffer.
// A behavioural model tracks bank state and stored contents.
// Each read pushes its expected pair onto a queue.
// The pair is popped and compared when the DUT presents the data.
module tb_aq_djpeg_idct_xpose;

  localparam int DESCALE = 12;
`ifdef AQ_DJPEG_XPOSE_SAT_EN
  localparam logic [31:0] SAT_HI = 32'h7fff;
  localparam logic [31:0] SAT_LO = 32'h8000;
`else
  localparam logic [31:0] SAT_HI = 32'h0000;
  localparam logic [31:0] SAT_LO = 32'h0000;
`endif

  logic        clk;
  logic        rst;
  logic        RowEnable;
  logic [2:0]  RowPage;
  logic [1:0]  RowCount;
  logic [31:0] Row0Data;
  logic [31:0] Row1Data;
  logic        RowReady;
  logic        Overrun;
  logic        ColEnable;
  logic        ColRead;
  logic [4:0]  ColAddress;
  logic [15:0] ColDataA;
  logic [15:0] ColDataB;

  aq_djpeg_idct_xpose #(.DESCALE(DESCALE)) dut (
    .clk(clk), .rst(rst),
    .RowEnable(RowEnable), .RowPage(RowPage), .RowCount(RowCount),
    .Row0Data(Row0Data), .Row1Data(Row1Data),
    .RowReady(RowReady), .Overrun(Overrun),
    .ColEnable(ColEnable), .ColRead(ColRead), .ColAddress(ColAddress),
    .ColDataA(ColDataA), .ColDataB(ColDataB)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int en_high = 0;

  // Reference model state.
  logic [15:0] mem_m [2][8][8];
  logic [1:0]  full_m;
  logic        wp_m;
  logic        rp_m;
  logic        reading_m;
  int          reads_m;
  logic [31:0] exp_q [$];
  int          rows_a [4] = '{0, 2, 1, 5};
  int          rows_b [4] = '{4, 6, 7, 3};

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Reference descale: 64-bit arithmetic, round half up, optional clamp.
  function automatic logic [15:0] sat_m(input logic [31:0] x);
    longint v;
    v = (longint'($signed(x)) + (64'sd1 <<< (DESCALE - 1))) >>> DESCALE;
`ifdef AQ_DJPEG_XPOSE_SAT_EN
    if (v > 32767) v = 32767;
    else if (v < -32768) v = -32768;
`endif
    return v[15:0];
  endfunction

  function automatic logic [31:0] pat(input int kind, input int row, input int col);
    logic [31:0] v;
    if (kind == 0) return 32'(4096 * (8 * row + col + 1));
    if (kind == 1 && col == 0) begin
      case (row)
        0: return 32'd2048;
        4: return 32'hffff_f7ff;
        2: return 32'd2047;
        6: return 32'h7fff_ffff;
        1: return 32'h8000_0000;
        7: return 32'hffff_f800;
        default: ;
      endcase
    end
    v = 32'((row * 8 + col + kind * 17) * 32'h0137_9a1d);
    return 32'($signed(v) >>> ((row + col + kind) % 20));
  endfunction

  task automatic modelReset();
    full_m    = 2'b00;
    wp_m      = 1'b0;
    rp_m      = 1'b0;
    reading_m = 1'b0;
    reads_m   = 0;
    exp_q.delete();
  endtask

  // One clock: update the model from the driven inputs, then check any read result.
  task automatic cycle();
    logic acc_w, done_w, acc_r, done_r;
    logic [31:0] e;
    int pg, ct;
    acc_w  = RowEnable && !full_m[wp_m];
    done_w = acc_w && RowPage == 3'd7 && RowCount == 2'd3;
    acc_r  = ColRead && full_m[rp_m];
    done_r = acc_r && reading_m && reads_m == 31;
    if (acc_r) begin
      pg = int'(ColAddress[4:2]);
      ct = int'(ColAddress[1:0]);
      exp_q.push_back({mem_m[rp_m][rows_a[ct]][pg], mem_m[rp_m][rows_b[ct]][pg]});
    end
    if (acc_w) begin
      mem_m[wp_m][RowPage][RowCount]      = sat_m(Row0Data);
      mem_m[wp_m][RowPage][7 - RowCount]  = sat_m(Row1Data);
    end
    if (done_r) begin
      full_m[rp_m] = 1'b0;
      rp_m         = !rp_m;
      reading_m    = 1'b0;
      reads_m      = 0;
    end else if (acc_r) begin
      reading_m = 1'b1;
      reads_m++;
    end
    if (done_w) begin
      full_m[wp_m] = 1'b1;
      wp_m         = !wp_m;
    end
    @(posedge clk);
    @(negedge clk);
    if (acc_r) begin
      if (exp_q.size() == 0) begin
        checkOutput("scoreboard_empty", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        checkOutput("col_data_a", {16'd0, ColDataA}, {16'd0, e[31:16]});
        checkOutput("col_data_b", {16'd0, ColDataB}, {16'd0, e[15:0]});
      end
    end
  endtask

  // Drive row beats first..last (beat index = 4*page + count) of a block pattern.
  task automatic applyStimulus(input int kind, input int first, input int last);
    for (int b = first; b <= last; b++) begin
      RowEnable = 1'b1;
      RowPage   = 3'(b / 4);
      RowCount  = 2'(b % 4);
      Row0Data  = pat(kind, b / 4, b % 4);
      Row1Data  = pat(kind, b / 4, 7 - (b % 4));
      cycle();
    end
    RowEnable = 1'b0;
  endtask

  // Issue n reads from address start upward; gapped reads in 4 of every 7 cycles.
  task automatic readBeats(input int start, input int n, input bit gapped);
    int issued = 0;
    int t = 0;
    while (issued < n) begin
      if (gapped && (t % 7) >= 4) begin
        ColRead = 1'b0;
      end else begin
        ColRead    = 1'b1;
        ColAddress = 5'(start + issued);
        issued++;
      end
      cycle();
      t++;
      if (gapped && issued < n && ColEnable !== 1'b0) en_high++;
    end
    ColRead = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst = 1'b0; RowEnable = 1'b0; RowPage = '0; RowCount = '0;
    Row0Data = '0; Row1Data = '0; ColRead = 1'b0; ColAddress = '0;
    modelReset();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("reset_row_ready", {31'd0, RowReady}, 32'd1);
    checkOutput("reset_overrun", {31'd0, Overrun}, 32'd0);
    checkOutput("reset_col_enable", {31'd0, ColEnable}, 32'd0);
    checkOutput("reset_col_a", {16'd0, ColDataA}, 32'd0);
    checkOutput("reset_col_b", {16'd0, ColDataB}, 32'd0);

    $display("[TB] block with scaled index pattern");
    applyStimulus(0, 0, 30);
    checkOutput("enable_before_last", {31'd0, ColEnable}, 32'd0);
    applyStimulus(0, 31, 31);
    checkOutput("enable_after_last", {31'd0, ColEnable}, 32'd1);
    checkOutput("ready_after_first_block", {31'd0, RowReady}, 32'd1);
    readBeats(14, 1, 1'b0);
    checkOutput("pair_3_2_a", {16'd0, ColDataA}, 32'd12);
    checkOutput("pair_3_2_b", {16'd0, ColDataB}, 32'd60);
    checkOutput("enable_drop_after_read", {31'd0, ColEnable}, 32'd0);
    readBeats(15, 31, 1'b0);
    checkOutput("enable_after_release", {31'd0, ColEnable}, 32'd0);
    checkOutput("ready_after_release", {31'd0, RowReady}, 32'd1);

    $display("[TB] rounding and saturation block");
    applyStimulus(1, 0, 31);
    readBeats(0, 1, 1'b0);
    checkOutput("round_2048", {16'd0, ColDataA}, 32'd1);
    checkOutput("round_m2049", {16'd0, ColDataB}, 32'hffff);
    readBeats(1, 1, 1'b0);
    checkOutput("round_2047", {16'd0, ColDataA}, 32'd0);
    checkOutput("sat_max", {16'd0, ColDataB}, SAT_HI);
    readBeats(2, 1, 1'b0);
    checkOutput("sat_min", {16'd0, ColDataA}, SAT_LO);
    checkOutput("round_m2048", {16'd0, ColDataB}, 32'd0);
    readBeats(3, 29, 1'b0);

    $display("[TB] ping-pong with overrun");
    applyStimulus(2, 0, 31);
    applyStimulus(3, 0, 31);
    checkOutput("ready_low_both_full", {31'd0, RowReady}, 32'd0);
    checkOutput("enable_both_full", {31'd0, ColEnable}, 32'd1);
    checkOutput("overrun_before", {31'd0, Overrun}, 32'd0);
    applyStimulus(6, 0, 31);
    checkOutput("overrun_set", {31'd0, Overrun}, 32'd1);
    readBeats(0, 31, 1'b0);
    checkOutput("ready_low_read31", {31'd0, RowReady}, 32'd0);
    readBeats(31, 1, 1'b0);
    checkOutput("ready_after_read32", {31'd0, RowReady}, 32'd1);
    checkOutput("enable_next_bank", {31'd0, ColEnable}, 32'd1);
    en_high = 0;
    readBeats(0, 32, 1'b1);
    checkOutput("enable_low_during_gapped", en_high, 32'd0);
    checkOutput("enable_after_gapped", {31'd0, ColEnable}, 32'd0);
    checkOutput("overrun_sticky", {31'd0, Overrun}, 32'd1);

    $display("[TB] reset in the middle of a block read");
    applyStimulus(4, 0, 31);
    checkOutput("enable_block4", {31'd0, ColEnable}, 32'd1);
    readBeats(5, 17, 1'b0);
    rst = 1'b0;
    #1;
    checkOutput("midreset_row_ready", {31'd0, RowReady}, 32'd1);
    checkOutput("midreset_overrun", {31'd0, Overrun}, 32'd0);
    checkOutput("midreset_col_enable", {31'd0, ColEnable}, 32'd0);
    checkOutput("midreset_col_a", {16'd0, ColDataA}, 32'd0);
    checkOutput("midreset_col_b", {16'd0, ColDataB}, 32'd0);
    modelReset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("post_reset_enable", {31'd0, ColEnable}, 32'd0);
    applyStimulus(5, 0, 31);
    checkOutput("enable_block5", {31'd0, ColEnable}, 32'd1);
    readBeats(9, 32, 1'b0);
    checkOutput("final_enable", {31'd0, ColEnable}, 32'd0);
    checkOutput("final_ready", {31'd0, RowReady}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
